// File: rtl/axil_simple_register_master_if.sv
// axi_lite: single-beat AXI-lite bus bundle, 32-bit address and data.
//
// Modports:
//   master  drives AW/W/AR channels and BREADY/RREADY.
//   slave   drives AWREADY/WREADY/ARREADY and the B/R channels.

interface axi_lite;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axil_simple_register_master.sv
// axil_simple_register_master: AXI-lite initiator issuing one single-beat
// register read or write at a time on behalf of local sequencing logic.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready only in IDLE
//   cmd_write             1 = write, 0 = read
//   cmd_address           register index (word granularity)
//   cmd_data, cmd_strobe  write data and byte strobes
//   rsp_valid/rsp_ready   response handshake
//   rsp_write             echo of the command direction
//   rsp_data              read data, 0 for writes
//   rsp_resp              BRESP/RRESP from the slave, forwarded unchanged
//   busy                  high whenever a transaction is in progress
//   axil                  AXI-lite master port
//
// state        | meaning
// -------------+-------------------------------------------------------
// IDLE         | waiting for a command, cmd_ready high
// WR_ADDR_DATA | AWVALID/WVALID outstanding until both handshakes done
// WR_RESP      | BREADY high, waiting for BVALID
// RD_ADDR      | ARVALID high, waiting for ARREADY
// RD_DATA      | RREADY high, waiting for RVALID
// RESPOND      | rsp_valid high, waiting for rsp_ready

module axil_simple_register_master #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0,
    parameter int          ADDRESS_WIDTH = 30
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [31:0]              cmd_data,
    input  logic [3:0]               cmd_strobe,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [31:0]              rsp_data,
    output logic [1:0]               rsp_resp,

    output logic                     busy,

    axi_lite.master                  axil
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESPOND
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] address_q;
    logic [31:0] data_q;
    logic [3:0]  strobe_q;
    logic        write_q;

    logic        aw_valid_q;
    logic        w_valid_q;
    logic        ar_valid_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        rsp_write_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_resp_q;

    logic [31:0] cmd_byte_offset;
    logic [31:0] cmd_bus_address;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        b_hs;
    logic        r_hs;
    logic        aw_complete;
    logic        w_complete;

    // Word index to byte address; the sum wraps modulo 2^32.
    assign cmd_byte_offset = 32'({cmd_address, 2'b00});
    assign cmd_bus_address = BASE_ADDRESS + cmd_byte_offset;

    assign accept = (state_q == IDLE) && cmd_valid;
    assign aw_hs  = aw_valid_q && axil.awready;
    assign w_hs   = w_valid_q && axil.wready;
    assign ar_hs  = ar_valid_q && axil.arready;
    assign b_hs   = (state_q == WR_RESP) && axil.bvalid;
    assign r_hs   = (state_q == RD_DATA) && axil.rvalid;

    // AW and W may complete in either order or together.
    assign aw_complete = aw_done_q || aw_hs;
    assign w_complete  = w_done_q || w_hs;

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        axil.bready = 1'b0;
        axil.rready = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (aw_complete && w_complete) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                axil.bready = 1'b1;
                if (axil.bvalid) begin
                    state_d = RESPOND;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                axil.rready = 1'b1;
                if (axil.rvalid) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            address_q   <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            write_q     <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q <= state_d;

            // Valids are registered so they rise the cycle after accept.
            if (accept) begin
                address_q  <= cmd_bus_address;
                data_q     <= cmd_data;
                strobe_q   <= cmd_strobe;
                write_q    <= cmd_write;
                aw_valid_q <= cmd_write;
                w_valid_q  <= cmd_write;
                ar_valid_q <= !cmd_write;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
            end

            if (aw_hs) begin
                aw_valid_q <= 1'b0;
                aw_done_q  <= 1'b1;
            end

            if (w_hs) begin
                w_valid_q <= 1'b0;
                w_done_q  <= 1'b1;
            end

            if (ar_hs) begin
                ar_valid_q <= 1'b0;
            end

            if (b_hs) begin
                rsp_write_q <= write_q;
                rsp_data_q  <= '0;
                rsp_resp_q  <= axil.bresp;
            end

            if (r_hs) begin
                rsp_write_q <= write_q;
                rsp_data_q  <= axil.rdata;
                rsp_resp_q  <= axil.rresp;
            end
        end
    end

    assign axil.awaddr  = address_q;
    assign axil.awprot  = 3'b000;
    assign axil.awvalid = aw_valid_q;
    assign axil.wdata   = data_q;
    assign axil.wstrb   = strobe_q;
    assign axil.wvalid  = w_valid_q;
    assign axil.araddr  = address_q;
    assign axil.arprot  = 3'b000;
    assign axil.arvalid = ar_valid_q;

    assign rsp_write = rsp_write_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: doc/axil_simple_register_master.md
Name: axil_simple_register_master

Overview:
- AXI-lite initiator that issues single-beat register reads and writes on behalf of local logic, e.g. a sequencer or bring-up engine that programs `axil_simple_register_cu`-style peripherals.
- Accepts one command at a time on a valid/ready command port, runs the full AXI-lite transaction, and returns the read data and response code on a valid/ready response port.
- Strictly one outstanding transaction.

Parameters:
- BASE_ADDRESS, 32'h0, byte address added to every command address.
- ADDRESS_WIDTH, 30, width of cmd_address (register index, word granularity).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDRESS_WIDTH  register index.
- cmd_data  in  32  write data; ignored for reads.
- cmd_strobe  in  4  write byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_data  out  32  read data; 0 for writes.
- rsp_resp  out  2  RRESP or BRESP returned by the slave.
- busy  out  1  high whenever state is not IDLE.
- axil  master  axi_lite interface (master modport)  AXI-lite bus.

Behaviour:
- Address computation: AxADDR = BASE_ADDRESS + {cmd_address, 2'b00}, modulo 2^32. Sum is latched at command accept.
- AxPROT = 3'b000 always.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE:
  - cmd_ready = 1 combinationally; it is 0 in all other states.
  - On cmd_valid: latch address, data, strobe and write flag.
  - Write command → WR_ADDR_DATA; read command → RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID and WVALID are registered and rise together on the cycle after accept.
  - Each drops independently on the cycle after its own handshake (AWVALID&AWREADY, WVALID&WREADY).
  - AWADDR, WDATA and WSTRB stay stable while the corresponding valid is high.
  - Once both handshakes have completed (same or different cycles) → WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP, set rsp_data = 0, rsp_write = 1 → RESPOND.
- RD_ADDR: ARVALID = 1, held until ARREADY, then → RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: capture RDATA and RRESP, set rsp_write = 0 → RESPOND.
- RESPOND:
  - rsp_valid = 1; rsp_* outputs held stable.
  - On rsp_ready → IDLE.
  - The next command can be accepted one cycle after the response handshake.
- Latency with a zero-wait slave:
  - Write: accept at cycle 0, AW/W handshake at 1, BVALID seen at 2 or later, rsp_valid from the cycle after the B handshake.
  - Read: accept at cycle 0, AR handshake at 1, RVALID seen at 2 or later, rsp_valid from the cycle after the R handshake.
- BREADY and RREADY are low outside WR_RESP and RD_DATA respectively. A BVALID or RVALID arriving in any other state is held by the slave per protocol and is not consumed.
- Non-OKAY responses (2'b10, 2'b11) are forwarded unchanged; there is no retry.
- Reset values:
  - State IDLE.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy = 0.
  - rsp_data = 0, rsp_resp = 0, rsp_write = 0.
  - Latched address, data and strobe = 0.
- Reset mid-transaction: all valids drop on the next edge and the FSM returns to IDLE with no response emitted. The system resets the slave in the same cycle.

Test Plan:
- Write, zero-wait slave: BASE_ADDRESS = 32'h4000_0000, cmd write index 3, data 32'hDEAD_BEEF, strobe 4'hF → AWADDR = 32'h4000_000C, WDATA = 32'hDEAD_BEEF, single AW/W handshake; rsp_valid with rsp_write = 1, rsp_resp = 0, rsp_data = 0.
- Read, slave delays ARREADY 3 cycles and returns RDATA = 32'h1234_5678, RRESP = 0 → ARADDR stable for all 4 ARVALID cycles; rsp_data = 32'h1234_5678.
- Skewed write handshakes: WREADY 2 cycles before AWREADY → WVALID drops first, AWVALID held; BREADY asserted only after both handshakes; exactly one response.
- Error and backpressure: slave returns BRESP = 2'b10, rsp_ready held low 5 cycles → rsp_valid and rsp_resp = 2'b10 stable for 5 cycles; cmd_ready stays 0 until one cycle after the rsp handshake.
- Back-to-back commands into an `axil_simple_register_cu`: write index 1 = 32'hA5, then read index 1 → read returns 32'hA5; no overlap of AW/W with AR on the bus.
- Reset asserted while ARVALID is high → ARVALID = 0, busy = 0 and no rsp_valid; a following read completes normally.
